// File: rtl/store_unit.sv
// Store unit: lane-aligns SB/SH/SW data onto a 32-bit Avalon-style write, holds it through waitrequest
// and pulses done/store_fault. Define STORE_UNALIGNED_EN to also accept SWL/SWR.
module store_unit #(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    input  logic        waitrequest,
    output logic [31:0] address,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    output logic        busy,
    output logic        done,
    output logic        store_fault
);

    localparam logic [5:0]  OP_SB      = 6'h28;
    localparam logic [5:0]  OP_SH      = 6'h29;
    localparam logic [5:0]  OP_SWL     = 6'h2A;
    localparam logic [5:0]  OP_SW      = 6'h2B;
    localparam logic [5:0]  OP_SWR     = 6'h2E;
    localparam bit          TIMEOUT_EN = (MAX_WAIT != 32'd0);
    localparam logic [31:0] WAIT_LAST  = 32'(MAX_WAIT) - 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] address_q;
    logic [31:0] writedata_q;
    logic [3:0]  byteenable_q;
    logic        write_q;
    logic        busy_q;
    logic        done_q;
    logic        fault_q;
    logic [31:0] wait_q;

    logic [5:0]  opcode_s;
    logic [1:0]  lane_s;
    logic [4:0]  shamt_s;
    logic        is_store_s;
    logic        legal_d;
    logic [3:0]  be_d;
    logic [31:0] wd_d;
    logic        unused_instr_s;

    assign opcode_s       = instruction[31:26];
    assign lane_s         = addr[1:0];
    assign shamt_s        = {lane_s, 3'b000};
    assign unused_instr_s = ^instruction[25:0];

`ifdef STORE_UNALIGNED_EN
    logic [1:0] top_lane_s;
    logic [4:0] swl_shamt_s;

    // SWL writes the most significant bytes of rt into lanes 0..n
    assign top_lane_s  = 2'd3 - lane_s;
    assign swl_shamt_s = {top_lane_s, 3'b000};
`endif

    // Decode the store opcode into legality, byte enables and lane-aligned data
    always_comb begin
        is_store_s = 1'b0;
        legal_d    = 1'b0;
        be_d       = 4'b0000;
        wd_d       = 32'h0000_0000;
        case (opcode_s)
            OP_SB: begin
                is_store_s = 1'b1;
                legal_d    = 1'b1;
                be_d       = 4'b0001 << lane_s;
                wd_d       = {24'h00_0000, rt_data[7:0]} << shamt_s;
            end
            OP_SH: begin
                is_store_s = 1'b1;
                if (lane_s[0] == 1'b0) begin
                    legal_d = 1'b1;
                    be_d    = 4'b0011 << lane_s;
                    wd_d    = {16'h0000, rt_data[15:0]} << shamt_s;
                end else begin
                    legal_d = 1'b0;
                end
            end
            OP_SW: begin
                is_store_s = 1'b1;
                if (lane_s == 2'd0) begin
                    legal_d = 1'b1;
                    be_d    = 4'b1111;
                    wd_d    = rt_data;
                end else begin
                    legal_d = 1'b0;
                end
            end
            OP_SWL: begin
                is_store_s = 1'b1;
`ifdef STORE_UNALIGNED_EN
                legal_d    = 1'b1;
                be_d       = 4'b1111 >> top_lane_s;
                wd_d       = rt_data >> swl_shamt_s;
`else
                legal_d    = 1'b0;
`endif
            end
            OP_SWR: begin
                is_store_s = 1'b1;
`ifdef STORE_UNALIGNED_EN
                legal_d    = 1'b1;
                be_d       = 4'b1111 << lane_s;
                wd_d       = rt_data << shamt_s;
`else
                legal_d    = 1'b0;
`endif
            end
            default: begin
                is_store_s = 1'b0;
                legal_d    = 1'b0;
            end
        endcase
    end

    // Store FSM with registered bus and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            address_q    <= 32'h0000_0000;
            writedata_q  <= 32'h0000_0000;
            byteenable_q <= 4'b0000;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            wait_q       <= 32'h0000_0000;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && is_store_s) begin
                        busy_q <= 1'b1;
                        if (legal_d) begin
                            state_q      <= ST_WRITE;
                            write_q      <= 1'b1;
                            address_q    <= {addr[31:2], 2'b00};
                            writedata_q  <= wd_d;
                            byteenable_q <= be_d;
                            wait_q       <= 32'h0000_0000;
                        end else begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // acceptance takes priority over a timeout on the same edge
                    if (!waitrequest) begin
                        state_q <= ST_DONE;
                        write_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
                        state_q <= ST_FAULT;
                        write_q <= 1'b0;
                        fault_q <= 1'b1;
                    end else if (TIMEOUT_EN) begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_FAULT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign address     = address_q;
    assign write       = write_q;
    assign writedata   = writedata_q;
    assign byteenable  = byteenable_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign store_fault = fault_q;

endmodule
